// File: rtl/sma_pkg.sv
// Shared constants for the sma read responder: default depths, address
// width and the counter-width helper used by the credit/outstanding logic.
package sma_pkg;

  localparam int DEF_DW  = 64;
  localparam int DEF_CQD = 4;
  localparam int DEF_RQD = 8;
  localparam int AW      = 32;

  // A counter that must hold every value 0..depth inclusive.
  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  localparam int DEF_CW = cnt_w(DEF_RQD);

endpackage

// File: rtl/sma_rsp_if.sv
// Bus bundle for sma_rsp: initiator command side, memory port, consumer
// data side, sticky error, and credit/outstanding counters exposed for
// debug visibility.
//
// Handshake rules (all sampled on the rising clock edge):
//   command : transfer when cmd && rdy; rdy depends only on registered state.
//   memory  : request transfers when mem_req && mem_gnt; mem_req holds until
//             granted; mem_vld carries one beat, returned in request order.
//   data    : transfer when dvl && dack; dvl/dat hold until taken.
interface sma_rsp_if
  import sma_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int RQD = DEF_RQD
);

  localparam int CW = cnt_w(RQD);

  logic          cmd;
  logic [AW-1:0] add;
  logic          rdy;
  logic          bzy;
  logic          mem_req;
  logic [AW-1:0] mem_add;
  logic          mem_gnt;
  logic          mem_vld;
  logic [DW-1:0] mem_dat;
  logic          dvl;
  logic [DW-1:0] dat;
  logic          dack;
  logic          err;
  logic [CW-1:0] credit;
  logic [CW-1:0] outs;

  // Responder view.
  modport slave (
    input  cmd, add, mem_gnt, mem_vld, mem_dat, dack,
    output rdy, bzy, mem_req, mem_add, dvl, dat, err, credit, outs
  );

  // Environment view (initiator, memory and consumer together).
  modport master (
    output cmd, add, mem_gnt, mem_vld, mem_dat, dack,
    input  rdy, bzy, mem_req, mem_add, dvl, dat, err, credit, outs
  );

endinterface

// File: rtl/sma_fifo.sv
// Synchronous FIFO with registered pointers carrying one extra wrap bit.
// Push and pop in the same cycle both take effect; a pop on a full FIFO
// frees the slot for the simultaneous push, and a push into an empty FIFO
// is never visible on dout in the same cycle.
module sma_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      wr_ptr;
  logic [PW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[PW] != rd_ptr[PW]) &&
                   (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr[PW-1:0]];

  // Pointer update; wrap comes for free from the power-of-two depth.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
      if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because empty masks them.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= din;
  end

endmodule

// File: rtl/sma_rsp.sv
// Read responder: queues initiator read commands, issues them to a memory
// port, buffers returning data and hands it to the consumer. A credit
// counter reserves a return-queue slot per accepted command so memory data
// always has room; protocol violations latch a sticky error.
module sma_rsp
  import sma_pkg::*;
#(
  parameter int DW  = DEF_DW,
  parameter int CQD = DEF_CQD,
  parameter int RQD = DEF_RQD
) (
  input logic      clk,
  input logic      rst,
  sma_rsp_if.slave bus
);

  localparam int CW = cnt_w(RQD);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(RQD);
  localparam logic [CW-1:0] CNT_ONE    = {{(CW-1){1'b0}}, 1'b1};

  logic          cmd_push;
  logic          cmd_pop;
  logic          cmd_full;
  logic          cmd_empty;
  logic [AW-1:0] cmd_head;

  logic          ret_push;
  logic          ret_pop;
  logic          ret_full;
  logic          ret_empty;
  logic [DW-1:0] ret_head;

  logic [CW-1:0] credit;
  logic [CW-1:0] outs;
  logic          err_q;
  logic          rdy_i;
  logic          vld_expected;
  logic          err_set;

  // Ready comes from registered state only, never from cmd.
  assign rdy_i    = !cmd_full && (credit < CREDIT_MAX);
  assign cmd_push = bus.cmd && rdy_i;
  assign cmd_pop  = !cmd_empty && bus.mem_gnt;
  assign ret_pop  = !ret_empty && bus.dack;

  // Memory data is only accepted against a granted, unreturned request;
  // a stray beat is dropped so credit accounting stays consistent.
  assign vld_expected = bus.mem_vld && (outs != '0);
  assign ret_push     = vld_expected;

  assign err_set = (bus.cmd && !rdy_i) ||
                   (bus.mem_vld && (outs == '0)) ||
                   (bus.mem_vld && ret_full && !ret_pop);

  sma_fifo #(
    .WIDTH (AW),
    .DEPTH (CQD)
  ) u_cmd_q (
    .clk   (clk),
    .rst   (rst),
    .push  (cmd_push),
    .pop   (cmd_pop),
    .din   (bus.add),
    .dout  (cmd_head),
    .full  (cmd_full),
    .empty (cmd_empty)
  );

  sma_fifo #(
    .WIDTH (DW),
    .DEPTH (RQD)
  ) u_ret_q (
    .clk   (clk),
    .rst   (rst),
    .push  (ret_push),
    .pop   (ret_pop),
    .din   (bus.mem_dat),
    .dout  (ret_head),
    .full  (ret_full),
    .empty (ret_empty)
  );

  // Credit: one slot reserved per accepted command, released on consumer take.
  always_ff @(posedge clk) begin
    if (rst) begin
      credit <= '0;
    end else begin
      case ({cmd_push, ret_pop})
        2'b10:   credit <= credit + CNT_ONE;
        2'b01:   credit <= credit - CNT_ONE;
        default: credit <= credit;
      endcase
    end
  end

  // Outstanding: requests granted by memory whose data has not come back.
  always_ff @(posedge clk) begin
    if (rst) begin
      outs <= '0;
    end else begin
      case ({cmd_pop, vld_expected})
        2'b10:   outs <= outs + CNT_ONE;
        2'b01:   outs <= outs - CNT_ONE;
        default: outs <= outs;
      endcase
    end
  end

  // Sticky protocol error; only reset clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (err_set) begin
      err_q <= 1'b1;
    end
  end

  assign bus.rdy     = rdy_i;
  assign bus.bzy     = (credit != '0);
  assign bus.mem_req = !cmd_empty;
  assign bus.mem_add = cmd_head;
  assign bus.dvl     = !ret_empty;
  assign bus.dat     = ret_head;
  assign bus.err     = err_q;
  assign bus.credit  = credit;
  assign bus.outs    = outs;

endmodule

// File: tb/tb_sma_rsp.sv
// Bench for sma_rsp: directed scenarios with a scoreboard of expected read
// data, a fixed-latency memory model and a negedge monitor on the data port.
module tb_sma_rsp;
  import sma_pkg::*;

  localparam int DW  = 64;
  localparam int CQD = 4;
  localparam int RQD = 8;

  typedef struct packed {
    logic          v;
    logic [AW-1:0] a;
  } slot_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  sma_rsp_if #(.DW(DW), .RQD(RQD)) bus ();

  sma_rsp #(.DW(DW), .CQD(CQD), .RQD(RQD)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int            checks = 0;
  int            errors = 0;
  int            n_ret  = 0;
  int            n_acc  = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] sb_exp;
  logic          spur_vld = 1'b0;
  slot_t         pipe[3] = '{default: '0};
  slot_t         g_cap = '0;
  logic          rst_seen = 1'b1;

  // clock / reset
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] mdata(input logic [AW-1:0] a);
    return {~a, a};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Drive point: 2 time units after the rising edge.
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic send_cmd(input logic [AW-1:0] a);
    int n;
    n = 0;
    while (!bus.rdy && n < 100) begin
      step();
      n++;
    end
    if (!bus.rdy) begin
      checks++;
      errors++;
      $display("FAIL send_cmd_timeout: got rdy=0 expected rdy=1 for add %0h", a);
    end else begin
      bus.cmd = 1'b1;
      bus.add = a;
      exp_q.push_back(mdata(a));
      step();
      bus.cmd = 1'b0;
    end
  endtask

  task automatic wait_idle(input string name);
    int n;
    n = 0;
    while (bus.bzy && n < 200) begin
      step();
      n++;
    end
    check(name, bus.bzy, 0);
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    exp_q.delete();
    step();
    rst = 1'b0;
  endtask

  // memory model: capture grants at negedge, return data three edges later
  always @(negedge clk) begin
    g_cap.v  = bus.mem_req && bus.mem_gnt && !rst;
    g_cap.a  = bus.mem_add;
    rst_seen = rst;
  end

  always @(posedge clk) begin
    #1;
    if (rst_seen) begin
      pipe = '{default: '0};
    end else begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = g_cap;
    end
    bus.mem_vld = pipe[2].v | spur_vld;
    bus.mem_dat = pipe[2].v ? mdata(pipe[2].a) : '0;
  end

  // scoreboard monitor on the consumer port
  always @(negedge clk) begin
    if (!rst && bus.dvl && bus.dack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_extra: got %0h expected no data", bus.dat);
      end else begin
        sb_exp = exp_q.pop_front();
        check("sb_dat", bus.dat, sb_exp);
        n_ret++;
      end
    end
  end

  // watchdog
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  // directed stimulus
  initial begin
    bus.cmd     = 1'b0;
    bus.add     = '0;
    bus.mem_gnt = 1'b0;
    bus.dack    = 1'b0;
    rst         = 1'b1;
    repeat (3) step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_rdy", bus.rdy, 1);
    check("rst_bzy", bus.bzy, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_dvl", bus.dvl, 0);
    check("rst_err", bus.err, 0);
    check("rst_credit", bus.credit, 0);
    step();

    // stream of 16 reads, free-flowing memory and consumer
    bus.mem_gnt = 1'b1;
    bus.dack    = 1'b1;
    for (int i = 0; i < 16; i++) send_cmd(32'h100 + i);
    wait_idle("stream_idle");
    check("stream_count", n_ret, 16);
    check("stream_err", bus.err, 0);
    check("stream_q_empty", exp_q.size(), 0);

    // consumer backpressure: credit limits acceptance to RQD
    bus.dack = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.rdy) begin
        bus.cmd = 1'b1;
        bus.add = 32'h300 + i;
        exp_q.push_back(mdata(32'h300 + i));
        n_acc++;
      end
      step();
      bus.cmd = 1'b0;
    end
    check("bp_accepted", n_acc, 8);
    check("bp_rdy_low", bus.rdy, 0);
    check("bp_credit", bus.credit, 8);
    repeat (6) step();
    check("bp_dvl", bus.dvl, 1);
    check("bp_outs", bus.outs, 0);
    bus.dack = 1'b1;
    step();
    bus.dack = 1'b0;
    check("bp_rdy_after_dack", bus.rdy, 1);
    check("bp_credit_after_dack", bus.credit, 7);

    // accept and take in the same cycle leaves credit unchanged
    bus.cmd  = 1'b1;
    bus.add  = 32'h310;
    exp_q.push_back(mdata(32'h310));
    bus.dack = 1'b1;
    step();
    bus.cmd  = 1'b0;
    bus.dack = 1'b0;
    check("sim_credit", bus.credit, 7);
    check("sim_rdy", bus.rdy, 1);
    check("sim_err", bus.err, 0);
    bus.cmd = 1'b1;
    bus.add = 32'h311;
    exp_q.push_back(mdata(32'h311));
    step();
    bus.cmd = 1'b0;
    check("full_credit", bus.credit, 8);
    check("full_rdy", bus.rdy, 0);
    bus.dack = 1'b1;
    wait_idle("bp_idle");
    check("bp_err", bus.err, 0);
    check("bp_q_empty", exp_q.size(), 0);

    // memory stall: command queue depth limits acceptance
    bus.mem_gnt = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 5; i++) begin
      if (bus.rdy) begin
        bus.cmd = 1'b1;
        bus.add = 32'h200 + i;
        exp_q.push_back(mdata(32'h200 + i));
        n_acc++;
      end
      step();
      bus.cmd = 1'b0;
    end
    check("stall_accepted", n_acc, 4);
    check("stall_rdy", bus.rdy, 0);
    bus.mem_gnt = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("stall_mem_req", bus.mem_req, 1);
      check("stall_mem_add", bus.mem_add, 32'h200 + k);
      step();
    end
    check("stall_drained", bus.mem_req, 0);
    wait_idle("stall_idle");
    check("stall_err", bus.err, 0);

    // command while not ready sets the sticky error
    bus.mem_gnt = 1'b0;
    for (int i = 0; i < 4; i++) send_cmd(32'h400 + i);
    check("ovf_rdy", bus.rdy, 0);
    bus.cmd = 1'b1;
    bus.add = 32'h4ff;
    step();
    bus.cmd = 1'b0;
    check("ovf_err", bus.err, 1);
    check("ovf_credit", bus.credit, 4);
    bus.mem_gnt = 1'b1;
    wait_idle("ovf_idle");
    check("ovf_err_held", bus.err, 1);
    pulse_rst();
    check("ovf_err_cleared", bus.err, 0);

    // stray memory data with nothing outstanding
    spur_vld = 1'b1;
    step();
    spur_vld = 1'b0;
    step();
    check("spur_err", bus.err, 1);
    repeat (5) step();
    check("spur_err_held", bus.err, 1);
    check("spur_dvl", bus.dvl, 0);
    pulse_rst();
    check("spur_err_cleared", bus.err, 0);

    // reset with reads queued, in flight and returning
    bus.mem_gnt = 1'b1;
    bus.dack    = 1'b0;
    for (int i = 0; i < 3; i++) send_cmd(32'h500 + i);
    step();
    rst = 1'b1;
    exp_q.delete();
    step();
    check("mid_rst_rdy", bus.rdy, 1);
    check("mid_rst_bzy", bus.bzy, 0);
    check("mid_rst_dvl", bus.dvl, 0);
    check("mid_rst_mem_req", bus.mem_req, 0);
    rst = 1'b0;
    repeat (6) step();
    check("post_rst_err", bus.err, 0);
    check("post_rst_dvl", bus.dvl, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
